// File: rtl/modulo_contador_garrafas_bcd.sv
// N-digit BCD bottle counter: synchronised sensor edges, saturation at a clamped limit.
// Define GARRAFAS_DEC_EN to add the `ret` input that decrements the count on removal.
module modulo_contador_garrafas_bcd #(
  parameter int N_DIG   = 2,
  parameter int SYNC_FF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sensor,
  input  logic               hab,
  input  logic               clr,
  input  logic [4*N_DIG-1:0] lim_bcd,
  output logic [4*N_DIG-1:0] dig_bcd,
  output logic               cheio,
  output logic               pulso_cheio,
  output logic               vazio
`ifdef GARRAFAS_DEC_EN
  ,
  input  logic               ret
`endif
);

  localparam int W = 4*N_DIG;

`ifdef GARRAFAS_DEC_EN
  localparam int NI = 2;
  logic [NI-1:0] raw;
  logic          rr;
  assign raw = {ret, sensor};
`else
  localparam int NI = 1;
  logic [NI-1:0] raw;
  logic          rr;
  assign raw = sensor;
`endif

  typedef enum logic [1:0] {
    PARADO,
    CONTANDO,
    CHEIO
  } st_t;

  st_t st, st_n;

  logic [SYNC_FF-1:0][NI-1:0] sq;
  logic [NI-1:0] sd;
  logic [NI-1:0] rise;
  logic          rs;
  logic [W-1:0]  lim;
  logic [W-1:0]  cnt_n;
  logic          pulso_n;
  logic          inc;
  logic          dec;

  assign rise = sq[SYNC_FF-1] & ~sd;
  assign rs   = rise[0];

`ifdef GARRAFAS_DEC_EN
  assign rr = rise[NI-1];
`else
  assign rr = 1'b0;
`endif

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic         c;
    logic [W-1:0] r;
    c = 1'b1;
    r = v;
    for (int i = 0; i < N_DIG; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic         b;
    logic [W-1:0] r;
    b = 1'b1;
    r = v;
    for (int i = 0; i < N_DIG; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // nibbles above 9 clamp to 9, so plain vector compares order like decimals
  always_comb begin
    lim = '0;
    for (int i = 0; i < N_DIG; i++) begin
      lim[4*i +: 4] = (lim_bcd[4*i +: 4] > 4'd9) ? 4'd9 : lim_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= PARADO;
    else        st <= st_n;
  end

  always_comb begin
    st_n  = st;
    cnt_n = dig_bcd;
    inc   = 1'b0;
    dec   = 1'b0;
    if (clr) begin
      cnt_n = '0;
      if (!hab)             st_n = PARADO;
      else if (lim == '0)   st_n = CHEIO;
      else                  st_n = CONTANDO;
    end else if (!hab) begin
      st_n = PARADO;
    end else if (st == PARADO) begin
      st_n = (dig_bcd >= lim) ? CHEIO : CONTANDO;
    end else begin
      inc = rs & ~rr & (st == CONTANDO) & (dig_bcd < lim);
      dec = rr & ~rs & (dig_bcd != '0);
      if (inc)      cnt_n = bcd_inc(dig_bcd);
      else if (dec) cnt_n = bcd_dec(dig_bcd);
      st_n = (cnt_n >= lim) ? CHEIO : CONTANDO;
    end
  end

  always_comb begin
    pulso_n = (st_n == CHEIO) && ((st != CHEIO) || clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq          <= '0;
      sd          <= '0;
      dig_bcd     <= '0;
      pulso_cheio <= 1'b0;
      vazio       <= 1'b1;
    end else begin
      sq          <= {sq[SYNC_FF-2:0], raw};
      sd          <= sq[SYNC_FF-1];
      dig_bcd     <= cnt_n;
      pulso_cheio <= pulso_n;
      vazio       <= (cnt_n == '0);
    end
  end

  assign cheio = (st == CHEIO);

endmodule

// File: tb/tb_modulo_contador_garrafas_bcd.sv
// Bench for modulo_contador_garrafas_bcd: decimal reference model plus directed checks.
// Exercises the ret path too when GARRAFAS_DEC_EN is defined.
module tb_modulo_contador_garrafas_bcd;

  localparam int ND = 2;
  localparam int SF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sensor = 1'b0;
  logic          ret = 1'b0;
  logic          hab = 1'b0;
  logic          clr = 1'b0;
  logic [4*ND-1:0] lim_bcd = 8'h99;
  logic [4*ND-1:0] dig_bcd;
  logic          cheio;
  logic          pulso_cheio;
  logic          vazio;

  int checks = 0;
  int errors = 0;
  int npul = 0;
  bit started = 0;

  modulo_contador_garrafas_bcd #(.N_DIG(ND), .SYNC_FF(SF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sensor(sensor),
    .hab(hab),
    .clr(clr),
    .lim_bcd(lim_bcd),
    .dig_bcd(dig_bcd),
    .cheio(cheio),
    .pulso_cheio(pulso_cheio),
    .vazio(vazio)
`ifdef GARRAFAS_DEC_EN
    ,
    .ret(ret)
`endif
  );

  always #5 clk = ~clk;

  function automatic int lim_dec(input logic [4*ND-1:0] l);
    int v = 0;
    int p = 1;
    int d;
    for (int i = 0; i < ND; i++) begin
      d = int'(l[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // model: count as an integer, mode 0 stopped / 1 counting / 2 full
  int mcnt = 0;
  int mmode = 0;
  bit mpul = 0;
  logic [7:0] sh = '0;
  logic [7:0] rh = '0;

  initial forever begin
    bit rs, rr, wasfull;
    int lv;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mcnt = 0; mmode = 0; mpul = 0; sh = '0; rh = '0;
    end else begin
      rs = sh[SF-1] & ~sh[SF];
      rr = rh[SF-1] & ~rh[SF];
      sh = {sh[6:0], sensor};
      rh = {rh[6:0], ret};
      lv = lim_dec(lim_bcd);
      wasfull = (mmode == 2);
      if (clr) begin
        mcnt = 0;
        mmode = !hab ? 0 : (lv == 0 ? 2 : 1);
      end else if (!hab) begin
        mmode = 0;
      end else if (mmode == 0) begin
        mmode = (mcnt >= lv) ? 2 : 1;
      end else begin
        if (rs && !rr) begin
          if (mmode == 1 && mcnt < lv) mcnt++;
        end else if (rr && !rs && mcnt > 0) begin
          mcnt--;
        end
        mmode = (mcnt >= lv) ? 2 : 1;
      end
      mpul = (mmode == 2) && (!wasfull || clr);
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (pulso_cheio) npul++;
    if (started) begin
      checks++;
      if (dig_bcd !== to_bcd(mcnt) || cheio !== (mmode == 2) ||
          pulso_cheio !== mpul || vazio !== (mcnt == 0)) begin
        errors++;
        $display("FAIL model t=%0t dig=%h/%h cheio=%b/%b pulso=%b/%b vazio=%b/%b",
                 $time, dig_bcd, to_bcd(mcnt), cheio, (mmode == 2),
                 pulso_cheio, mpul, vazio, (mcnt == 0));
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int len);
    sensor = 1'b1;
    cyc(len);
    sensor = 1'b0;
    cyc(3);
  endtask

  task automatic pulses(input int n);
    repeat (n) pulse(1);
  endtask

  task automatic rpulse();
    ret = 1'b1;
    cyc(1);
    ret = 1'b0;
    cyc(3);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    // reset with a toggling sensor
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sensor = ~sensor;
    end
    sensor = 1'b0;
    #1;
    chk("rst_dig", int'(dig_bcd), 0);
    chk("rst_vazio", int'(vazio), 1);
    chk("rst_cheio", int'(cheio), 0);
    chk("rst_pulso", int'(pulso_cheio), 0);
    @(negedge clk);
    rst_n = 1'b1;
    started = 1;
    cyc(4);
    hab = 1'b1;
    cyc(2);
    chk("run_cheio", int'(cheio), 0);

    // carry through digits, then a long pulse counts once
    pulses(19);
    chk("carry19", int'(dig_bcd), 'h19);
    pulse(20);
    chk("long_pulse", int'(dig_bcd), 'h20);
    chk("not_vazio", int'(vazio), 0);

    // saturation at 12
    lim_bcd = 8'h12;
    do_clr();
    npul = 0;
    pulses(15);
    chk("sat_dig", int'(dig_bcd), 'h12);
    chk("sat_cheio", int'(cheio), 1);
    chk("sat_npul", npul, 1);

    // clamped limit, raise, then lower below count
    lim_bcd = 8'h1F;
    do_clr();
    npul = 0;
    pulses(19);
    chk("clamp_dig", int'(dig_bcd), 'h19);
    chk("clamp_cheio", int'(cheio), 1);
    lim_bcd = 8'h30;
    cyc(2);
    chk("raise_cheio", int'(cheio), 0);
    pulses(2);
    chk("raise_dig", int'(dig_bcd), 'h21);
    chk("raise_npul", npul, 1);
    lim_bcd = 8'h05;
    cyc(2);
    chk("lower_dig", int'(dig_bcd), 'h21);
    chk("lower_cheio", int'(cheio), 1);
    chk("lower_npul", npul, 2);

    // clr beats an edge in the same cycle; hab=0 discards edges
    lim_bcd = 8'h99;
    do_clr();
    pulses(7);
    chk("pre_clr", int'(dig_bcd), 'h07);
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    cyc(1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(3);
    chk("clr_edge_dig", int'(dig_bcd), 0);
    chk("clr_edge_vazio", int'(vazio), 1);
    hab = 1'b0;
    pulses(5);
    chk("hab0_dig", int'(dig_bcd), 0);
    hab = 1'b1;
    cyc(2);

`ifdef GARRAFAS_DEC_EN
    pulses(10);
    rpulse();
    chk("ret_borrow", int'(dig_bcd), 'h09);
    do_clr();
    rpulse();
    chk("ret_zero", int'(dig_bcd), 0);
    pulses(5);
    sensor = 1'b1;
    ret = 1'b1;
    cyc(1);
    sensor = 1'b0;
    ret = 1'b0;
    cyc(3);
    chk("net_zero", int'(dig_bcd), 'h05);
    lim_bcd = 8'h12;
    pulses(10);
    rpulse();
    chk("ret_cheio_dig", int'(dig_bcd), 'h11);
    chk("ret_cheio", int'(cheio), 0);
    lim_bcd = 8'h99;
    do_clr();
`endif

    // randomized run against the model
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 3) == 0) sensor = ~sensor;
`ifdef GARRAFAS_DEC_EN
      if ($urandom_range(0, 5) == 0) ret = ~ret;
`endif
      if ($urandom_range(0, 49) == 0) hab = ~hab;
      clr = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 3) == 0) lim_bcd = 8'($urandom);
        else lim_bcd = to_bcd(int'($urandom_range(0, 40)));
      end
    end
    rst_n = 1'b1;
    clr = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
